// File: rtl/core_general_pkg.sv
// Shared core-wide definitions for the localbus arbiter.
// Provides the default data/address width and the arbiter state encoding.
// There are no ports; modules import this package.
package core_general_pkg;

    // Default data and address width of the core localbus.
    localparam int CORE_XLEN = 32;

    // Arbiter states. OWNn means requester n was granted in the previous cycle.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

endpackage

// File: rtl/localbus_arbiter.sv
// Two-requester localbus arbiter (requester 0 = core, requester 1 = DMA/loader).
// Round-robin arbitration with optional bus locking limited to BURST_MAX
// consecutive grants. The winner drives the shared bus in the same cycle, and read
// data is returned one cycle later to the requester that issued the read.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqN, lockN              request / keep-ownership request from requester N
//   addrN, wdataN, weN       requester N access (weN == 0 means read)
//   gntN                     requester N access issued this cycle
//   rvalidN, rdataN          read data returned to requester N
//   bus_addr/bus_wdata/bus_we  shared localbus drive
//   bus_qout                 localbus read data, valid one cycle after address
module localbus_arbiter
    import core_general_pkg::*;
#(
    parameter int XLEN      = CORE_XLEN,
    parameter int BURST_MAX = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            req1,
    input  logic            lock0,
    input  logic            lock1,
    input  logic [XLEN-1:0] addr0,
    input  logic [XLEN-1:0] addr1,
    input  logic [XLEN-1:0] wdata0,
    input  logic [XLEN-1:0] wdata1,
    input  logic [3:0]      we0,
    input  logic [3:0]      we1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            rvalid0,
    output logic            rvalid1,
    output logic [XLEN-1:0] rdata0,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_we,
    input  logic [XLEN-1:0] bus_qout
);

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0] BURST_LIMIT = BW'(BURST_MAX);

    logic [1:0]      state_reg, state_next;
    logic            rr_reg, rr_next;        // 1: requester 1 wins a tie
    logic [BW-1:0]   burst_reg, burst_next;
    logic [BW-1:0]   burst_inc;
    logic            tag_reg, tag_next;      // requester owning the outstanding read
    logic            tag_valid_reg, tag_valid_next;
    logic [XLEN-1:0] addr_hold_reg, wdata_hold_reg;
    logic [XLEN-1:0] rdata0_reg, rdata1_reg;
    logic            hold0, hold1;
    logic            gnt0_int, gnt1_int;

    // Owner keeps the bus while it still requests, locks and has burst budget.
    assign hold0 = (state_reg == ST_OWN0) && req0 && lock0 && (burst_reg < BURST_LIMIT);
    assign hold1 = (state_reg == ST_OWN1) && req1 && lock1 && (burst_reg < BURST_LIMIT);

    // Arbitration decision: locked owner first, otherwise round-robin.
    always_comb begin
        gnt0_int = 1'b0;
        gnt1_int = 1'b0;
        if (hold0) begin
            gnt0_int = 1'b1;
        end else if (hold1) begin
            gnt1_int = 1'b1;
        end else if (req0 && req1) begin
            if (rr_reg) gnt1_int = 1'b1;
            else        gnt0_int = 1'b1;
        end else if (req0) begin
            gnt0_int = 1'b1;
        end else if (req1) begin
            gnt1_int = 1'b1;
        end
    end

    // Saturating increment keeps the counter at the limit when nobody else
    // is waiting and the owner simply carries on.
    assign burst_inc = (burst_reg == BURST_LIMIT) ? burst_reg : burst_reg + BW'(1);

    always_comb begin
        state_next     = ST_IDLE;
        rr_next        = rr_reg;
        burst_next     = '0;
        tag_next       = tag_reg;
        tag_valid_next = 1'b0;
        if (gnt0_int) begin
            state_next     = ST_OWN0;
            rr_next        = 1'b1;
            // A locked grant starts (or continues) a burst; unlocked grants do not count.
            burst_next     = lock0 ? ((state_reg == ST_OWN0) ? burst_inc : BW'(1)) : '0;
            tag_next       = 1'b0;
            tag_valid_next = (we0 == 4'b0000);
        end else if (gnt1_int) begin
            state_next     = ST_OWN1;
            rr_next        = 1'b0;
            burst_next     = lock1 ? ((state_reg == ST_OWN1) ? burst_inc : BW'(1)) : '0;
            tag_next       = 1'b1;
            tag_valid_next = (we1 == 4'b0000);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            rr_reg         <= 1'b0;
            burst_reg      <= '0;
            tag_reg        <= 1'b0;
            tag_valid_reg  <= 1'b0;
            addr_hold_reg  <= '0;
            wdata_hold_reg <= '0;
            rdata0_reg     <= '0;
            rdata1_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            rr_reg        <= rr_next;
            burst_reg     <= burst_next;
            tag_reg       <= tag_next;
            tag_valid_reg <= tag_valid_next;
            if (gnt0_int || gnt1_int) begin
                addr_hold_reg  <= bus_addr;
                wdata_hold_reg <= bus_wdata;
            end
            if (rvalid0) rdata0_reg <= bus_qout;
            if (rvalid1) rdata1_reg <= bus_qout;
        end
    end

    // Grants and the bus drive are combinational, so they are gated by reset
    // to make every output read zero as soon as reset is raised.
    assign gnt0 = gnt0_int & ~rst;
    assign gnt1 = gnt1_int & ~rst;

    always_comb begin
        bus_we    = 4'b0000;
        bus_addr  = addr_hold_reg;
        bus_wdata = wdata_hold_reg;
        if (gnt0) begin
            bus_we    = we0;
            bus_addr  = addr0;
            bus_wdata = wdata0;
        end else if (gnt1) begin
            bus_we    = we1;
            bus_addr  = addr1;
            bus_wdata = wdata1;
        end
    end

    // Read return: bus_qout is live in the cycle after the address, so it is
    // forwarded directly and captured to hold the value afterwards.
    assign rvalid0 = tag_valid_reg & ~tag_reg;
    assign rvalid1 = tag_valid_reg &  tag_reg;
    assign rdata0  = rvalid0 ? bus_qout : rdata0_reg;
    assign rdata1  = rvalid1 ? bus_qout : rdata1_reg;

endmodule
